// File: rtl/imem_loader.sv
// imem_loader: streams a program image into instruction memory over valid/ready,
// holding fetch off while loading. Define IMEM_LOADER_CKSUM_EN to add the cksum output.
module imem_loader #(
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [31:0]               base_addr,
   input  logic [MEM_ADDR_WIDTH:0]   length,
   input  logic                      s_valid,
   input  logic [31:0]               s_data,
   output logic                      s_ready,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_wdata,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
`ifdef IMEM_LOADER_CKSUM_EN
   output logic [31:0]               cksum,
`endif
   output logic                      core_hold
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [MEM_ADDR_WIDTH:0]   LEN_ZERO = {(MEM_ADDR_WIDTH+1){1'b0}};
   localparam logic [MEM_ADDR_WIDTH:0]   LEN_ONE  = {{MEM_ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [MEM_ADDR_WIDTH-1:0] PTR_ONE  = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                    state_r, state_s;
   logic [MEM_ADDR_WIDTH-1:0] wptr_r;
   logic [MEM_ADDR_WIDTH:0]   remaining_r;
   logic                      s_ready_r, mem_we_r, busy_r, done_r, err_r, hold_r;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
   logic [31:0]               mem_wdata_r;
   logic                      req_s, reject_s, accept_s, beat_s;
   logic                      ready_s, busy_s, done_s, hold_s;
   logic                      unused_s;

   assign unused_s = ^base_addr[31:MEM_ADDR_WIDTH+2];

   // Start qualification: misaligned base or oversize length is rejected
   always_comb begin
      req_s    = (state_r == ST_IDLE) && start;
      reject_s = req_s && ((base_addr[1:0] != 2'b00) ||
                           (length[MEM_ADDR_WIDTH] && (|length[MEM_ADDR_WIDTH-1:0])));
      accept_s = req_s && !reject_s;
      beat_s   = s_valid && s_ready_r;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = (length == LEN_ZERO) ? ST_DONE : ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (beat_s && (remaining_r == LEN_ONE)) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_DRAIN: state_s = ST_DONE;
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so status outputs come straight from flops
   always_comb begin
      ready_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      hold_s  = 1'b0;
      case (state_s)
         ST_IDLE: begin
            hold_s = 1'b0;
         end
         ST_LOAD: begin
            ready_s = 1'b1;
            busy_s  = 1'b1;
            hold_s  = 1'b1;
         end
         ST_DRAIN: begin
            busy_s = 1'b1;
            hold_s = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
            hold_s = 1'b1;
         end
         default: begin
            ready_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b0;
            hold_s  = 1'b0;
         end
      endcase
   end

   // Status output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         s_ready_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         hold_r    <= 1'b0;
      end else begin
         s_ready_r <= ready_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         err_r     <= reject_s;
         hold_r    <= hold_s;
      end
   end

   // Write pointer, beat counter and the registered memory write port
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r      <= {MEM_ADDR_WIDTH{1'b0}};
         remaining_r <= LEN_ZERO;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {MEM_ADDR_WIDTH{1'b0}};
         mem_wdata_r <= 32'h0000_0000;
      end else begin
         mem_we_r <= beat_s;
         if (accept_s) begin
            wptr_r      <= base_addr[MEM_ADDR_WIDTH+1:2];
            remaining_r <= length;
         end else if (beat_s) begin
            wptr_r      <= wptr_r + PTR_ONE;
            remaining_r <= remaining_r - LEN_ONE;
         end
         if (beat_s) begin
            mem_addr_r  <= wptr_r;
            mem_wdata_r <= s_data;
         end
      end
   end

`ifdef IMEM_LOADER_CKSUM_EN
   logic [31:0] cksum_r;

   // Running sum of accepted words, cleared by each accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         cksum_r <= 32'h0000_0000;
      end else if (accept_s) begin
         cksum_r <= 32'h0000_0000;
      end else if (beat_s) begin
         cksum_r <= cksum_r + s_data;
      end
   end

   assign cksum = cksum_r;
`endif

   assign s_ready   = s_ready_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign core_hold = hold_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a queue-based model.
// Checksum checks are included when IMEM_LOADER_CKSUM_EN is defined.
module tb_imem_loader;
   localparam int W = 10;

   logic          clk = 1'b0;
   logic          reset, start, s_valid;
   logic [31:0]   base_addr, s_data;
   logic [W:0]    length;
   logic          s_ready, mem_we, busy, done, err, core_hold;
   logic [W-1:0]  mem_addr;
   logic [31:0]   mem_wdata;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [31:0]   cksum;
   logic [31:0]   ck_at_done;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [W-1:0]  obs_addr[$];
   logic [31:0]   obs_data[$];
   int            obs_cyc[$];
   int            done_cyc[$];
   int            err_cyc[$];
   int            both_cnt = 0;

   logic [31:0]   wq[$];
   bit            vpat[$];
   int            beat_cyc[$];
   logic [W-1:0]  exp_addr[$];
   logic [31:0]   exp_data[$];
   int            exp_cyc[$];
   int            exp_done;

   imem_loader #(.MEM_ADDR_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
`ifdef IMEM_LOADER_CKSUM_EN
      .cksum(cksum),
`endif
      .core_hold(core_hold)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor: record every write, done and err seen on the falling edge
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         obs_addr.push_back(mem_addr);
         obs_data.push_back(mem_wdata);
         obs_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cyc.push_back(cyc);
`ifdef IMEM_LOADER_CKSUM_EN
         ck_at_done = cksum;
`endif
      end
      if (err === 1'b1) err_cyc.push_back(cyc);
      if (done === 1'b1 && err === 1'b1) both_cnt++;
   end

   task automatic clear_obs();
      @(posedge clk);
      obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
      done_cyc.delete(); err_cyc.delete(); beat_cyc.delete();
   endtask

   task automatic fill_words(input int n);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
   endtask

   // Reference: beat i lands at word (base/4 + i) mod depth one cycle after its beat; done two after the last
   task automatic model_expect(input logic [31:0] base);
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      for (int i = 0; i < beat_cyc.size(); i++) begin
         exp_addr.push_back(W'(((base >> 2) + i) % (1 << W)));
         exp_data.push_back(wq[i]);
         exp_cyc.push_back(beat_cyc[i] + 1);
      end
      exp_done = (beat_cyc.size() > 0) ? beat_cyc[beat_cyc.size()-1] + 2 : -1;
   endtask

   // Stimulus only: start a load and stream wq, optionally re-pulsing start mid-load
   task automatic do_load(input logic [31:0] base, input logic [W:0] len, input int gap_pct,
                          input bit poke, output int sent, output bit ready_ok);
      int guard;
      clear_obs();
      @(negedge clk);
      start = 1'b1; base_addr = base; length = len;
      @(negedge clk);
      start = 1'b0;
      sent = 0; guard = 0; ready_ok = 1'b1;
      while (sent < int'(len) && guard < 500) begin
         if (poke && guard == 1) begin
            start = 1'b1; base_addr = 32'h0000_0100; length = (W+1)'(7);
         end else begin
            start = 1'b0;
         end
         if (vpat.size() > 0) s_valid = vpat.pop_front();
         else s_valid = ($urandom_range(99) >= gap_pct);
         s_data = wq[sent];
         if (s_ready !== 1'b1 || busy !== 1'b1 || core_hold !== 1'b1) ready_ok = 1'b0;
         if (s_valid && s_ready === 1'b1) begin
            beat_cyc.push_back(cyc);
            sent++;
         end
         @(negedge clk);
         guard++;
      end
      s_valid = 1'b0; start = 1'b0;
      vpat.delete();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; s_valid = 1'b0; base_addr = 32'h0; length = '0; s_data = 32'h0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_hold} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got ready=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b hold=%b, expected all 0",
                  s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_hold);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int sent; bit rdy;
      wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      do_load(32'h40, (W+1)'(4), 0, 1'b0, sent, rdy);
      model_expect(32'h40);
      tests_run++;
      if (obs_addr.size() != 4 || sent != 4) begin
         tests_failed++;
         $display("FAIL basic_count: got %0d writes (%0d beats), expected 4", obs_addr.size(), sent);
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         tests_run++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] !== exp_cyc[i]) begin
            tests_failed++;
            $display("FAIL basic_write%0d: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                     i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
         end
      end
      tests_run++;
      if (obs_cyc.size() == 4 && obs_cyc[3] - obs_cyc[0] != 3) begin
         tests_failed++;
         $display("FAIL basic_b2b: got write span %0d cycles, expected 3", obs_cyc[3] - obs_cyc[0]);
      end
      tests_run++;
      if (done_cyc.size() != 1 || done_cyc[0] != exp_done) begin
         tests_failed++;
         $display("FAIL basic_done: got %0d pulses first at %0d, expected 1 at %0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
      end
      tests_run++;
      if (core_hold !== 1'b0 || busy !== 1'b0 || !rdy) begin
         tests_failed++;
         $display("FAIL basic_hold: got hold=%b busy=%b during_load_ok=%b, expected 0 0 1", core_hold, busy, rdy);
      end
   endtask

   task automatic test_gapped();
      int sent; bit rdy;
      fill_words(3);
      vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      do_load(32'h0, (W+1)'(3), 0, 1'b0, sent, rdy);
      model_expect(32'h0);
      tests_run++;
      if (obs_addr.size() != 3 || !rdy) begin
         tests_failed++;
         $display("FAIL gapped_count: got %0d writes ready_ok=%b, expected 3 and 1", obs_addr.size(), rdy);
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         tests_run++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] !== exp_cyc[i]) begin
            tests_failed++;
            $display("FAIL gapped_write%0d: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                     i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_rejects();
      logic [W:0] lens[3];
      logic [31:0] bases[3];
      bases = '{32'h42, 32'h0, 32'h80};
      lens  = '{(W+1)'(2), (W+1)'((1 << W) + 1), (W+1)'(0)};
      for (int k = 0; k < 3; k++) begin
         clear_obs();
         @(negedge clk);
         start = 1'b1; base_addr = bases[k]; length = lens[k];
         @(negedge clk);
         start = 1'b0;
         tests_run++;
         if (k < 2 && (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || core_hold !== 1'b0)) begin
            tests_failed++;
            $display("FAIL reject%0d_pulse: got err=%b busy=%b done=%b hold=%b, expected 1 0 0 0", k, err, busy, done, core_hold);
         end else if (k == 2 && (done !== 1'b1 || err !== 1'b0 || core_hold !== 1'b1)) begin
            tests_failed++;
            $display("FAIL zero_len_done: got done=%b err=%b hold=%b, expected 1 0 1", done, err, core_hold);
         end
         repeat (3) @(negedge clk);
         tests_run++;
         if (obs_addr.size() != 0 || err_cyc.size() != ((k < 2) ? 1 : 0) || done_cyc.size() != ((k < 2) ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL reject%0d_after: got writes=%0d errs=%0d dones=%0d, expected 0 %0d %0d",
                     k, obs_addr.size(), err_cyc.size(), done_cyc.size(), (k < 2) ? 1 : 0, (k < 2) ? 0 : 1);
         end
      end
   endtask

   task automatic test_wrap();
      int sent; bit rdy;
      fill_words(4);
      do_load(32'hFF8, (W+1)'(4), 30, 1'b0, sent, rdy);
      model_expect(32'hFF8);
      tests_run++;
      if (obs_addr.size() != 4 || obs_addr[0] !== W'(10'h3FE) || obs_addr[2] !== W'(10'h000)) begin
         tests_failed++;
         $display("FAIL wrap_addrs: got %0d writes first=%h third=%h, expected 4 3fe 000",
                  obs_addr.size(), obs_addr[0], obs_addr[2]);
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         tests_run++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] !== exp_cyc[i]) begin
            tests_failed++;
            $display("FAIL wrap_write%0d: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                     i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_reset_midload();
      int sent, guard; bit rdy;
      fill_words(5);
      clear_obs();
      @(negedge clk);
      start = 1'b1; base_addr = 32'h200; length = (W+1)'(5);
      @(negedge clk);
      start = 1'b0; sent = 0; guard = 0;
      while (sent < 2 && guard < 50) begin
         s_valid = 1'b1; s_data = wq[sent];
         if (s_ready === 1'b1) begin beat_cyc.push_back(cyc); sent++; end
         @(negedge clk);
         guard++;
      end
      s_valid = 1'b1; s_data = wq[2]; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; s_valid = 1'b0;
      tests_run++;
      if (core_hold !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || sent != 2) begin
         tests_failed++;
         $display("FAIL midreset_state: got hold=%b we=%b busy=%b ready=%b beats=%0d, expected 0 0 0 0 2",
                  core_hold, mem_we, busy, s_ready, sent);
      end
      repeat (4) @(negedge clk);
      model_expect(32'h200);
      tests_run++;
      if (obs_addr.size() != 2 || done_cyc.size() != 0 || obs_addr[0] !== exp_addr[0] || obs_addr[1] !== exp_addr[1]
          || obs_data[1] !== exp_data[1]) begin
         tests_failed++;
         $display("FAIL midreset_writes: got %0d writes %0d dones, expected 2 writes at %h,%h and 0 dones",
                  obs_addr.size(), done_cyc.size(), exp_addr[0], exp_addr[1]);
      end
      fill_words(1);
      do_load(32'h10, (W+1)'(1), 0, 1'b0, sent, rdy);
      model_expect(32'h10);
      tests_run++;
      if (obs_addr.size() != 1 || obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]
          || done_cyc.size() != 1 || done_cyc[0] != exp_done) begin
         tests_failed++;
         $display("FAIL fresh_load: got %0d writes %0d dones, expected 1 write at %h and done at %0d",
                  obs_addr.size(), done_cyc.size(), exp_addr[0], exp_done);
      end
      fill_words(4);
      do_load(32'h300, (W+1)'(4), 0, 1'b1, sent, rdy);
      model_expect(32'h300);
      tests_run++;
      if (obs_addr.size() != 4 || err_cyc.size() != 0 || done_cyc.size() != 1 || obs_addr[3] !== exp_addr[3]) begin
         tests_failed++;
         $display("FAIL ignored_start: got %0d writes %0d errs %0d dones last=%h, expected 4 0 1 last=%h",
                  obs_addr.size(), err_cyc.size(), done_cyc.size(), obs_addr[3], exp_addr[3]);
      end
   endtask

   task automatic test_random();
      int sent; bit rdy;
      logic [31:0] base;
      int n;
      for (int t = 0; t < 8; t++) begin
         base = $urandom & 32'hFFFF_FFFC;
         n = $urandom_range(1, 24);
         fill_words(n);
         do_load(base, (W+1)'(n), $urandom_range(0, 60), 1'b0, sent, rdy);
         model_expect(base);
         tests_run++;
         if (obs_addr.size() != n || sent != n || !rdy || done_cyc.size() != 1 || done_cyc[0] != exp_done) begin
            tests_failed++;
            $display("FAIL random%0d_shape: got %0d writes %0d beats ready_ok=%b %0d dones, expected %0d writes 1 done at %0d",
                     t, obs_addr.size(), sent, rdy, done_cyc.size(), n, exp_done);
         end
         for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            tests_run++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] !== exp_cyc[i]) begin
               tests_failed++;
               $display("FAIL random%0d_write%0d: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                        t, i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
            end
         end
`ifdef IMEM_LOADER_CKSUM_EN
         begin
            logic [31:0] sum;
            sum = 32'h0;
            foreach (wq[i]) sum = sum + wq[i];
            tests_run++;
            if (ck_at_done !== sum) begin
               tests_failed++;
               $display("FAIL random%0d_cksum: got %h, expected %h", t, ck_at_done, sum);
            end
         end
`endif
      end
   endtask

`ifdef IMEM_LOADER_CKSUM_EN
   task automatic test_cksum();
      int sent; bit rdy;
      wq = '{32'hFFFF_FFFF, 32'h0000_0002};
      do_load(32'h0, (W+1)'(2), 0, 1'b0, sent, rdy);
      tests_run++;
      if (ck_at_done !== 32'h0000_0001 || cksum !== 32'h0000_0001) begin
         tests_failed++;
         $display("FAIL cksum: got at_done=%h now=%h, expected 00000001", ck_at_done, cksum);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_rejects();
      test_wrap();
      test_reset_midload();
      test_random();
`ifdef IMEM_LOADER_CKSUM_EN
      test_cksum();
`endif
      tests_run++;
      if (both_cnt != 0) begin
         tests_failed++;
         $display("FAIL done_err_overlap: got %0d overlapping cycles, expected 0", both_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the fetch-stage instruction memory read port.
- Accepts a program image as a stream of 32-bit words over a valid/ready handshake and writes it into instruction memory through a registered single-word write port.
- Holds the core off fetch (`core_hold`) while a load is in progress.
- Sits between the boot/debug link and the instruction memory, beside the fetch stage.

Parameters:
- MEM_ADDR_WIDTH, 10, word-address width of instruction memory (depth = 2^MEM_ADDR_WIDTH words).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- base_addr  input  32  byte address of the first word; must be word-aligned
- length  input  MEM_ADDR_WIDTH+1  number of words to load
- s_valid  input  1  stream word valid
- s_data  input  32  stream word
- s_ready  output  1  loader accepts a word this cycle
- mem_we  output  1  instruction memory write enable
- mem_addr  output  MEM_ADDR_WIDTH  word address of the write
- mem_wdata  output  32  write data
- busy  output  1  high in LOAD and DRAIN
- done  output  1  one-cycle pulse when a load completes
- err  output  1  one-cycle pulse when a start is rejected
- core_hold  output  1  stall request to fetch

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; internal counters 0.
- States and transitions:
  - IDLE, on start:
    - base_addr[1:0]!=0 or length>2^MEM_ADDR_WIDTH: pulse err next cycle, stay IDLE.
    - length==0: go to DONE. No writes.
    - Otherwise: latch wptr=base_addr[MEM_ADDR_WIDTH+1:2] and remaining=length, go to LOAD.
  - LOAD:
    - s_ready = 1 while remaining>0.
    - A beat is accepted when s_valid && s_ready.
    - Each accepted beat registers mem_we=1, mem_addr=wptr, mem_wdata=s_data for exactly the next cycle (latency 1).
    - On each accepted beat: wptr increments; remaining decrements.
    - Accepting the last beat (remaining==1) moves to DRAIN.
  - DRAIN: one cycle, during which the final write is presented on mem_we. s_ready=0. Then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- core_hold: high from the cycle after an accepted (non-error) start through the DONE cycle inclusive. Low in IDLE.
- Stream gaps (s_valid=0): no write that cycle; mem_we=0; state holds. No timeout.
- Address wrap: wptr arithmetic is modulo 2^MEM_ADDR_WIDTH. A load starting near the top wraps to word 0.
- start outside IDLE is ignored: no err, no effect.
- mem_we is never high in two cycles without a matching accepted beat. Back-to-back beats give back-to-back writes at consecutive addresses.
- Reset during LOAD or DRAIN:
  - Returns to IDLE on the next edge; mem_we=0 and done is not pulsed.
  - A write already registered is dropped. Words written earlier remain in memory.
- done and err are never asserted in the same cycle.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- When defined:
  - Adds output port cksum (32 bits), a running modulo-2^32 sum of all accepted s_data words.
  - cksum clears to 0 on each accepted start and on reset.
  - cksum is valid and stable from the DONE cycle until the next accepted start.
- When undefined: no cksum port and no adder. All other behaviour is identical.

Test Plan:
- Basic load: reset, start with base_addr=0x40, length=4, stream 0xA0..0xA3 back-to-back.
  - mem_we high 4 consecutive cycles at mem_addr 0x10..0x13 with matching data.
  - done pulses 2 cycles after the last beat.
  - core_hold low after done.
- Gapped stream: length=3, s_valid toggles 1,0,0,1,0,1.
  - Exactly 3 writes, to words 0,1,2, each one cycle after its beat.
  - s_ready stays 1 until the third beat.
- Rejects:
  - start with base_addr=0x42: err pulse, no writes, busy=0.
  - start with length=2^MEM_ADDR_WIDTH+1: err pulse.
  - start with length=0: done pulse, no mem_we, no err.
- Wrap: MEM_ADDR_WIDTH=10, base_addr=0xFF8, length=4 → writes to words 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-load and ignored start:
  - Assert reset after 2 of 5 beats: only those 2 writes occur, no done, core_hold=0 after reset.
  - Then a fresh load of 1 word succeeds.
  - A second start issued during LOAD is ignored.
- Checksum (IMEM_LOADER_CKSUM_EN): load 0xFFFFFFFF, 0x00000002 → cksum=0x00000001 at done.
